// File: rtl/data_mem_arb.sv
// rtl/data_mem_arb.sv - single-ported L1 data memory shared by CPU and DMA with a starvation-bounded arbiter
module data_mem_arb #(
    parameter int    DATA_WIDTH      = 32,
    parameter int    DATA_ADDR_WIDTH = 32,
    parameter int    NUM_WORDS       = 128,
    parameter int    DMA_MAX_WAIT    = 4,
    parameter string INIT_FILE       = ""
) (
    input  logic                         cpu_clk,
    input  logic                         cpu_rst_n,

    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [DATA_WIDTH/8-1:0]      cpu_be,
    input  logic [DATA_ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]        cpu_wdata,
    output logic                         cpu_gnt,
    output logic                         cpu_rvalid,
    output logic [DATA_WIDTH-1:0]        cpu_rdata,
    output logic                         cpu_err,
    output logic                         data_mem_hazard,

    input  logic                         dma_req,
    input  logic                         dma_we,
    input  logic [DATA_WIDTH/8-1:0]      dma_be,
    input  logic [DATA_ADDR_WIDTH-1:0]   dma_addr,
    input  logic [DATA_WIDTH-1:0]        dma_wdata,
    output logic                         dma_gnt,
    output logic                         dma_rvalid,
    output logic [DATA_WIDTH-1:0]        dma_rdata,
    output logic                         dma_err
);

    localparam int IDX_W  = $clog2(NUM_WORDS);
    localparam int BE_W   = DATA_WIDTH / 8;
    localparam int WAIT_W = (DMA_MAX_WAIT > 0) ? $clog2(DMA_MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(DMA_MAX_WAIT);

    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

    logic [WAIT_W-1:0]     wait_cnt;
    logic                  boost;
    logic                  cpu_oor;
    logic                  dma_oor;
    logic                  cpu_rerr_q;
    logic                  dma_rerr_q;

    logic                  acc_en;
    logic                  acc_we;
    logic                  acc_oor;
    logic [BE_W-1:0]       acc_be;
    logic [IDX_W-1:0]      acc_idx;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [DATA_WIDTH-1:0] rd_word;

    // Any address bit above the index field means the word does not exist.
    always_comb begin
        cpu_oor = |cpu_addr[DATA_ADDR_WIDTH-1:IDX_W];
        dma_oor = |dma_addr[DATA_ADDR_WIDTH-1:IDX_W];
    end

    // Single-grant arbiter: CPU first, unless DMA has waited long enough to be boosted.
    always_comb begin
        boost           = (DMA_MAX_WAIT != 0) && (wait_cnt == WAIT_MAX);
        dma_gnt         = dma_req && (boost || !cpu_req);
        cpu_gnt         = cpu_req && !dma_gnt;
        data_mem_hazard = cpu_req && !cpu_gnt;
    end

    // The granted port owns the array port this cycle.
    always_comb begin
        acc_en    = cpu_gnt || dma_gnt;
        acc_we    = dma_gnt ? dma_we    : cpu_we;
        acc_oor   = dma_gnt ? dma_oor   : cpu_oor;
        acc_be    = dma_gnt ? dma_be    : cpu_be;
        acc_idx   = dma_gnt ? dma_addr[IDX_W-1:0] : cpu_addr[IDX_W-1:0];
        acc_wdata = dma_gnt ? dma_wdata : cpu_wdata;
        rd_word   = acc_oor ? '0 : mem[acc_idx];
    end

    // Write errors are reported in the grant cycle; read errors ride with rvalid.
    always_comb begin
        cpu_err = cpu_rerr_q || (cpu_gnt && cpu_we && cpu_oor);
        dma_err = dma_rerr_q || (dma_gnt && dma_we && dma_oor);
    end

    // Byte-enabled write at the end of the grant cycle; out-of-range writes are dropped.
    always_ff @(posedge cpu_clk) begin
        if (acc_en && acc_we && !acc_oor) begin
            for (int i = 0; i < BE_W; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read return: one rvalid pulse per read grant, dropped by reset.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            cpu_rerr_q <= 1'b0;
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
            dma_rerr_q <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_gnt && !cpu_we;
            cpu_rerr_q <= cpu_gnt && !cpu_we && cpu_oor;
            dma_rvalid <= dma_gnt && !dma_we;
            dma_rerr_q <= dma_gnt && !dma_we && dma_oor;
            if (cpu_gnt && !cpu_we) begin
                cpu_rdata <= rd_word;
            end
            if (dma_gnt && !dma_we) begin
                dma_rdata <= rd_word;
            end
        end
    end

    // Count refused DMA cycles up to the boost threshold; any DMA grant restarts it.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            wait_cnt <= '0;
        end else if (dma_gnt) begin
            wait_cnt <= '0;
        end else if (dma_req && (wait_cnt != WAIT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_data_mem_arb.sv
// tb/tb_data_mem_arb.sv - directed self-checking bench for data_mem_arb
module tb_data_mem_arb;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NW = 128;

    logic          cpu_clk = 1'b0;
    logic          cpu_rst_n = 1'b0;

    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [3:0]    cpu_be, dma_be;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata;

    logic          cpu_gnt, cpu_rvalid, cpu_err, data_mem_hazard;
    logic [DW-1:0] cpu_rdata;
    logic          dma_gnt, dma_rvalid, dma_err;
    logic [DW-1:0] dma_rdata;

    logic          d0_cpu_gnt, d0_cpu_rvalid, d0_cpu_err, d0_hazard;
    logic [DW-1:0] d0_cpu_rdata;
    logic          d0_dma_gnt, d0_dma_rvalid, d0_dma_err;
    logic [DW-1:0] d0_dma_rdata;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] shadow [NW];

    always #5 cpu_clk = ~cpu_clk;

    data_mem_arb #(.DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW), .NUM_WORDS(NW), .DMA_MAX_WAIT(4)) dut (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .data_mem_hazard(data_mem_hazard),
        .dma_req(dma_req), .dma_we(dma_we), .dma_be(dma_be), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_err(dma_err)
    );

    data_mem_arb #(.DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW), .NUM_WORDS(NW), .DMA_MAX_WAIT(0)) dut0 (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(d0_cpu_gnt), .cpu_rvalid(d0_cpu_rvalid), .cpu_rdata(d0_cpu_rdata), .cpu_err(d0_cpu_err),
        .data_mem_hazard(d0_hazard),
        .dma_req(dma_req), .dma_we(dma_we), .dma_be(dma_be), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(d0_dma_gnt), .dma_rvalid(d0_dma_rvalid), .dma_rdata(d0_dma_rdata), .dma_err(d0_dma_err)
    );

    function automatic logic [DW-1:0] pat(input int i);
        return {8'hA5, 8'(i), 8'(~i), 8'h3C};
    endfunction

    task automatic cpu_cycle(input logic we, input logic [3:0] be, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wd, output logic g, output logic e);
        cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wd;
        #1; g = cpu_gnt; e = cpu_err;
        @(negedge cpu_clk);
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic dma_cycle(input logic we, input logic [3:0] be, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wd, output logic g, output logic e);
        dma_req = 1'b1; dma_we = we; dma_be = be; dma_addr = addr; dma_wdata = wd;
        #1; g = dma_gnt; e = dma_err;
        @(negedge cpu_clk);
        dma_req = 1'b0; dma_we = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge cpu_clk); #1;
        n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_rvalid got %b exp 0", cpu_rvalid); end
        n_checks++; if (cpu_rdata !== '0) begin n_fail++; $display("FAIL reset_cpu_rdata got %h exp 0", cpu_rdata); end
        n_checks++; if (cpu_err !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_err got %b exp 0", cpu_err); end
        n_checks++; if (dma_rvalid !== 1'b0 || dma_rdata !== '0 || dma_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_dma_outputs got rv=%b rd=%h err=%b exp 0/0/0", dma_rvalid, dma_rdata, dma_err); end
        n_checks++; if (cpu_gnt !== 1'b0 || data_mem_hazard !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_gnt got gnt=%b hz=%b exp 0/0", cpu_gnt, data_mem_hazard); end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 0;
        #1;
        n_checks++; if (cpu_gnt !== 1'b1 || data_mem_hazard !== 1'b0) begin
            n_fail++; $display("FAIL reset_gnt_follows_req got gnt=%b hz=%b exp 1/0", cpu_gnt, data_mem_hazard); end
        cpu_req = 1'b0;
        @(negedge cpu_clk); #1;
        n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_no_rvalid got %b exp 0", cpu_rvalid); end
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
    endtask

    task automatic test_fill();
        logic g, e;
        for (int i = 0; i < NW; i++) begin
            cpu_cycle(1'b1, 4'hF, AW'(i), pat(i), g, e);
            shadow[i] = pat(i);
            n_checks++; if (g !== 1'b1 || e !== 1'b0) begin
                n_fail++; $display("FAIL fill_gnt[%0d] got gnt=%b err=%b exp 1/0", i, g, e); end
        end
    endtask

    task automatic test_byte_enable();
        logic g, e;
        cpu_cycle(1'b1, 4'hF, 5, 32'h11223344, g, e);
        cpu_cycle(1'b1, 4'b0101, 5, 32'hAABBCCDD, g, e);
        shadow[5] = 32'h11BB33DD;
        n_checks++; if (g !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL be_write_gnt got gnt=%b err=%b exp 1/0", g, e); end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5;
        #1;
        n_checks++; if (cpu_gnt !== 1'b1 || cpu_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL be_read_grant_cycle got gnt=%b rv=%b exp 1/0", cpu_gnt, cpu_rvalid); end
        @(negedge cpu_clk);
        cpu_req = 1'b0;
        #1;
        n_checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h11BB33DD || cpu_err !== 1'b0) begin
            n_fail++; $display("FAIL be_read_data got rv=%b rd=%h err=%b exp 1/11bb33dd/0", cpu_rvalid, cpu_rdata, cpu_err); end
        @(negedge cpu_clk); #1;
        n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL be_rvalid_pulse got %b exp 0", cpu_rvalid); end
        cpu_cycle(1'b1, 4'b0000, 5, 32'hFFFFFFFF, g, e);
        cpu_cycle(1'b0, 4'h0, 5, 32'h0, g, e);
        #1;
        n_checks++; if (cpu_rdata !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_zero_noop got %h exp 11bb33dd", cpu_rdata); end
    endtask

    task automatic test_reset_mid_read();
        logic g, e;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10;
        #1;
        n_checks++; if (cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL midrd_gnt got %b exp 1", cpu_gnt); end
        @(posedge cpu_clk); #1;
        cpu_rst_n = 1'b0; cpu_req = 1'b0;
        @(negedge cpu_clk); #1;
        n_checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== '0 || cpu_err !== 1'b0 || data_mem_hazard !== 1'b0) begin
            n_fail++; $display("FAIL midrd_dropped got rv=%b rd=%h err=%b hz=%b exp 0/0/0/0", cpu_rvalid, cpu_rdata, cpu_err, data_mem_hazard); end
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        cpu_cycle(1'b0, 4'h0, 10, 32'h0, g, e);
        #1;
        n_checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== shadow[10]) begin
            n_fail++; $display("FAIL midrd_retained got rv=%b rd=%h exp 1/%h", cpu_rvalid, cpu_rdata, shadow[10]); end
    endtask

    task automatic test_arb_boost();
        logic prev_c, prev_d, exp_d;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 1;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 2;
        prev_c = 1'b0; prev_d = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            exp_d = (k % 5 == 4);
            n_checks++; if (dma_gnt !== exp_d || cpu_gnt !== !exp_d || data_mem_hazard !== exp_d) begin
                n_fail++; $display("FAIL arb_cycle%0d got dg=%b cg=%b hz=%b exp %b/%b/%b", k, dma_gnt, cpu_gnt, data_mem_hazard, exp_d, !exp_d, exp_d); end
            if (k > 0) begin
                n_checks++; if (cpu_rvalid !== prev_c || dma_rvalid !== prev_d) begin
                    n_fail++; $display("FAIL arb_rvalid%0d got c=%b d=%b exp %b/%b", k, cpu_rvalid, dma_rvalid, prev_c, prev_d); end
                if (prev_d) begin
                    n_checks++; if (dma_rdata !== shadow[2]) begin n_fail++; $display("FAIL arb_dma_rdata got %h exp %h", dma_rdata, shadow[2]); end
                end else begin
                    n_checks++; if (cpu_rdata !== shadow[1]) begin n_fail++; $display("FAIL arb_cpu_rdata got %h exp %h", cpu_rdata, shadow[1]); end
                end
            end
            prev_c = !exp_d; prev_d = exp_d;
            @(negedge cpu_clk);
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        #1;
        n_checks++; if (dma_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || dma_rdata !== shadow[2]) begin
            n_fail++; $display("FAIL arb_last got drv=%b crv=%b rd=%h exp 1/0/%h", dma_rvalid, cpu_rvalid, dma_rdata, shadow[2]); end
        @(negedge cpu_clk);
    endtask

    task automatic test_strict_priority();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 3;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 4;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_checks++; if (d0_dma_gnt !== 1'b0 || d0_cpu_gnt !== 1'b1 || d0_hazard !== 1'b0) begin
                n_fail++; $display("FAIL strict_cycle%0d got dg=%b cg=%b hz=%b exp 0/1/0", k, d0_dma_gnt, d0_cpu_gnt, d0_hazard); end
            @(negedge cpu_clk);
        end
        cpu_req = 1'b0;
        #1;
        n_checks++; if (d0_dma_gnt !== 1'b1 || d0_cpu_gnt !== 1'b0) begin
            n_fail++; $display("FAIL strict_release got dg=%b cg=%b exp 1/0", d0_dma_gnt, d0_cpu_gnt); end
        @(negedge cpu_clk);
        dma_req = 1'b0;
        #1;
        n_checks++; if (d0_dma_rvalid !== 1'b1 || d0_dma_rdata !== shadow[4]) begin
            n_fail++; $display("FAIL strict_dma_read got rv=%b rd=%h exp 1/%h", d0_dma_rvalid, d0_dma_rdata, shadow[4]); end
        @(negedge cpu_clk);
    endtask

    task automatic test_range();
        logic g, e;
        cpu_cycle(1'b0, 4'h0, 128, 32'h0, g, e);
        #1;
        n_checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== '0 || cpu_err !== 1'b1) begin
            n_fail++; $display("FAIL oor_read got rv=%b rd=%h err=%b exp 1/0/1", cpu_rvalid, cpu_rdata, cpu_err); end
        cpu_cycle(1'b1, 4'hF, 200, 32'hFFFF0000, g, e);
        n_checks++; if (g !== 1'b1 || e !== 1'b1) begin n_fail++; $display("FAIL oor_write_err got gnt=%b err=%b exp 1/1", g, e); end
        #1;
        n_checks++; if (cpu_err !== 1'b0 || cpu_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL oor_err_cleared got err=%b rv=%b exp 0/0", cpu_err, cpu_rvalid); end
        dma_cycle(1'b0, 4'h0, 32'h80000005, 32'h0, g, e);
        #1;
        n_checks++; if (dma_rvalid !== 1'b1 || dma_rdata !== '0 || dma_err !== 1'b1) begin
            n_fail++; $display("FAIL oor_dma_read got rv=%b rd=%h err=%b exp 1/0/1", dma_rvalid, dma_rdata, dma_err); end
        for (int i = 0; i < NW; i++) begin
            cpu_cycle(1'b0, 4'h0, AW'(i), 32'h0, g, e);
            #1;
            n_checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== shadow[i] || cpu_err !== 1'b0) begin
                n_fail++; $display("FAIL sweep[%0d] got rv=%b rd=%h err=%b exp 1/%h/0", i, cpu_rvalid, cpu_rdata, cpu_err, shadow[i]); end
        end
    endtask

    task automatic test_dma_write_cpu_read();
        logic g, e;
        dma_cycle(1'b1, 4'hF, 7, 32'hDEADBEEF, g, e);
        n_checks++; if (g !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL dmawr_gnt got gnt=%b err=%b exp 1/0", g, e); end
        shadow[7] = 32'hDEADBEEF;
        cpu_cycle(1'b0, 4'h0, 7, 32'h0, g, e);
        #1;
        n_checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL dmawr_cpu_read got rv=%b rd=%h exp 1/deadbeef", cpu_rvalid, cpu_rdata); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 4'h0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_be = 4'h0; dma_addr = '0; dma_wdata = '0;
        test_reset();
        test_fill();
        test_byte_enable();
        test_reset_mid_read();
        test_arb_boost();
        test_strict_priority();
        test_range();
        test_dma_write_cpu_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
